// File: rtl/mcu_pkg.sv
// Shared definitions for the 8-bit microcontroller control unit: FSM states,
// instruction class codes, ALU mode codes and flag bit positions.
package mcu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  // Instruction class, taken from IR[15:14]
  localparam logic [1:0] CLS_ALU_REG = 2'b00;
  localparam logic [1:0] CLS_ALU_IMM = 2'b01;
  localparam logic [1:0] CLS_JMP     = 2'b10;
  localparam logic [1:0] CLS_SYS     = 2'b11;

  // Jump condition codes, taken from IR[13:12]
  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_C      = 2'b10;
  localparam logic [1:0] COND_S      = 2'b11;

  // System sub-operation selecting HALT, taken from IR[13:12]
  localparam logic [1:0] SYS_HALT = 2'b01;

  // ALU operation codes driven on alu_mode
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_NOT  = 4'b0110;
  localparam logic [3:0] ALU_ADC  = 4'b0111;
  localparam logic [3:0] ALU_SBC  = 4'b1000;
  localparam logic [3:0] ALU_CMP  = 4'b1001;
  localparam logic [3:0] ALU_SHL  = 4'b1010;
  localparam logic [3:0] ALU_SHR  = 4'b1011;
  localparam logic [3:0] ALU_ROL  = 4'b1100;
  localparam logic [3:0] ALU_ROR  = 4'b1101;
  localparam logic [3:0] ALU_SWAP = 4'b1110;
  localparam logic [3:0] ALU_NEG  = 4'b1111;

  // Bit positions inside the {Z,C,S,O} flag nibble
  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_S = 1;
  localparam int FLG_O = 0;

  // Only arithmetic modes produce a meaningful carry; all others keep C
  function automatic logic modeWritesCarry(input logic [3:0] mode);
    case (mode)
      ALU_ADD, ALU_SUB, ALU_ADC, ALU_SBC, ALU_CMP, ALU_NEG: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcu_regfile.sv
// 16 x 8 general-purpose register file: one combinational read port and
// one synchronous write port, cleared by the asynchronous reset.
module mcu_regfile
  import mcu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wrEn,
  input  logic [3:0] i_wrAddr,
  input  logic [7:0] i_wrData,
  input  logic [3:0] i_rdAddr,
  output logic [7:0] o_rdData
);

  logic [7:0] r_mem [16];

  // Clear every register on reset, otherwise write one entry when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/mcu_sequencer.sv
// Multi-cycle control unit: fetches 16-bit instructions, drives the ALU,
// writes results back to ACC or the register file and resolves jumps.
module mcu_sequencer
  import mcu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic        alu_en,
  output logic [3:0]  alu_mode,
  output logic [7:0]  alu_op1,
  output logic [7:0]  alu_op2,
  output logic [3:0]  alu_rflags,
  input  logic [7:0]  alu_result,
  input  logic [3:0]  alu_wflags,
  output logic [7:0]  acc,
  output logic        halted
);

  state_t      r_state;
  logic [7:0]  r_pc;
  logic [15:0] r_ir;
  logic [7:0]  r_acc;
  logic [3:0]  r_flags;
  logic        r_aluEn;
  logic [3:0]  r_aluMode;
  logic        r_halted;

  logic [1:0]  w_class;
  logic        w_destReg;
  logic        w_rfWrEn;
  logic [7:0]  w_rdData;
  logic        w_jmpTaken;

  assign w_class   = r_ir[15:14];
  assign w_destReg = (w_class == CLS_ALU_REG) && r_ir[9];
  assign w_rfWrEn  = (r_state == ST_WRITEBACK) && w_destReg;

  mcu_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wrEn   (w_rfWrEn),
    .i_wrAddr (r_ir[3:0]),
    .i_wrData (alu_result),
    .i_rdAddr (r_ir[3:0]),
    .o_rdData (w_rdData)
  );

  // Resolve the jump condition against the stored flags; cond 00 ignores invert
  always_comb begin
    w_jmpTaken = 1'b0;
    case (r_ir[13:12])
      COND_ALWAYS: w_jmpTaken = 1'b1;
      COND_Z:      w_jmpTaken = r_flags[FLG_Z] ^ r_ir[11];
      COND_C:      w_jmpTaken = r_flags[FLG_C] ^ r_ir[11];
      COND_S:      w_jmpTaken = r_flags[FLG_S] ^ r_ir[11];
      default:     w_jmpTaken = 1'b0;
    endcase
  end

  // Main control FSM with PC, IR, ACC, flags and registered ALU controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= 16'h0000;
      r_acc     <= 8'h00;
      r_flags   <= 4'b0000;
      r_aluEn   <= 1'b0;
      r_aluMode <= 4'b0000;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_valid) begin
            r_ir    <= imem_data;
            r_pc    <= r_pc + 8'd1;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (w_class)
            CLS_ALU_REG, CLS_ALU_IMM: begin
              r_aluEn   <= 1'b1;
              r_aluMode <= r_ir[13:10];
              r_state   <= ST_EXECUTE;
            end
            CLS_JMP: begin
              if (w_jmpTaken) begin
                r_pc <= r_ir[7:0];
              end
              r_state <= ST_FETCH;
            end
            default: begin
              if (r_ir[13:12] == SYS_HALT) begin
                r_halted <= 1'b1;
                r_state  <= ST_HALT;
              end else begin
                r_state <= ST_FETCH;
              end
            end
          endcase
        end
        ST_EXECUTE: begin
          r_state <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          if (!w_destReg) begin
            r_acc <= alu_result;
          end
          r_flags[FLG_Z] <= alu_wflags[FLG_Z];
          r_flags[FLG_S] <= alu_wflags[FLG_S];
          r_flags[FLG_O] <= alu_wflags[FLG_O];
          if (modeWritesCarry(r_aluMode)) begin
            r_flags[FLG_C] <= alu_wflags[FLG_C];
          end
          r_aluEn   <= 1'b0;
          r_aluMode <= 4'b0000;
          r_state   <= ST_FETCH;
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  assign imem_req   = (r_state == ST_FETCH) && rst_n;
  assign imem_addr  = r_pc;
  assign alu_en     = r_aluEn;
  assign alu_mode   = r_aluMode;
  assign alu_op1    = !r_aluEn ? 8'h00 : (w_class == CLS_ALU_IMM) ? r_ir[7:0] : w_rdData;
  assign alu_op2    = r_aluEn ? r_acc : 8'h00;
  assign alu_rflags = r_flags;
  assign acc        = r_acc;
  assign halted     = r_halted;

endmodule

// File: tb/tb_mcu_sequencer.sv
// Directed testbench for mcu_sequencer with a small behavioural ALU attached.
module tb_mcu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic        alu_en;
  logic [3:0]  alu_mode;
  logic [7:0]  alu_op1;
  logic [7:0]  alu_op2;
  logic [3:0]  alu_rflags;
  logic [7:0]  alu_result;
  logic [3:0]  alu_wflags;
  logic [7:0]  acc;
  logic        halted;

  int vecCount;
  int missCount;

  mcu_sequencer #(.RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_valid (imem_valid),
    .alu_en     (alu_en),
    .alu_mode   (alu_mode),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_rflags (alu_rflags),
    .alu_result (alu_result),
    .alu_wflags (alu_wflags),
    .acc        (acc),
    .halted     (halted)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: ADD, OR and AND; anything else passes operand2 through
  always_comb begin
    logic [8:0] sum;
    sum        = {1'b0, alu_op1} + {1'b0, alu_op2};
    alu_result = alu_op2;
    alu_wflags = 4'b0000;
    case (alu_mode)
      4'b0000: begin
        alu_result    = sum[7:0];
        alu_wflags[2] = sum[8];
        alu_wflags[0] = (alu_op1[7] == alu_op2[7]) && (sum[7] != alu_op1[7]);
      end
      4'b0011: alu_result = alu_op1 | alu_op2;
      4'b0100: alu_result = alu_op1 & alu_op2;
      default: alu_result = alu_op2;
    endcase
    alu_wflags[3] = (alu_result == 8'h00);
    alu_wflags[1] = alu_result[7];
  end

  // Wait (bounded) for a fetch request, then present one instruction for one cycle
  task automatic applyStimulus(input logic [15:0] instr);
    int waitCycles = 0;
    while (imem_req !== 1'b1 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    vecCount++;
    if (imem_req !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL fetch_wait: imem_req=%b, required 1 within 20 cycles", imem_req);
    end
    imem_data  = instr;
    imem_valid = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    imem_valid = 1'b0;
    imem_data  = 16'h0000;
    repeat (3) @(negedge clk);
    vecCount++;
    if (imem_req !== 1'b0) begin
      missCount++; $display("[TB] FAIL reset_req_low: got %b, required 0", imem_req);
    end
    rst_n = 1'b1;
    #1;
    vecCount++;
    if (imem_req !== 1'b1) begin
      missCount++; $display("[TB] FAIL reset_req: got %b, required 1", imem_req);
    end
    vecCount++;
    if (imem_addr !== 8'h00) begin
      missCount++; $display("[TB] FAIL reset_addr: got %h, required 00", imem_addr);
    end
    vecCount++;
    if (acc !== 8'h00) begin
      missCount++; $display("[TB] FAIL reset_acc: got %h, required 00", acc);
    end
    vecCount++;
    if (alu_rflags !== 4'b0000) begin
      missCount++; $display("[TB] FAIL reset_flags: got %b, required 0000", alu_rflags);
    end
    vecCount++;
    if (halted !== 1'b0 || alu_en !== 1'b0 || alu_mode !== 4'b0000) begin
      missCount++;
      $display("[TB] FAIL reset_idle: halted=%b alu_en=%b alu_mode=%b, required 0 0 0000", halted, alu_en, alu_mode);
    end
    @(negedge clk);
  endtask

  task automatic test_alu_imm();
    applyStimulus(16'h4005);
    vecCount++;
    if (alu_en !== 1'b0) begin
      missCount++; $display("[TB] FAIL decode_alu_en: got %b, required 0", alu_en);
    end
    @(negedge clk);
    vecCount++;
    if (alu_en !== 1'b1 || alu_mode !== 4'b0000 || alu_op1 !== 8'h05 || alu_op2 !== 8'h00) begin
      missCount++;
      $display("[TB] FAIL exec_drive: en=%b mode=%b op1=%h op2=%h, required 1 0000 05 00", alu_en, alu_mode, alu_op1, alu_op2);
    end
    @(negedge clk);
    vecCount++;
    if (alu_en !== 1'b1 || alu_op1 !== 8'h05) begin
      missCount++; $display("[TB] FAIL wb_hold: en=%b op1=%h, required 1 05", alu_en, alu_op1);
    end
    @(negedge clk);
    vecCount++;
    if (acc !== 8'h05 || alu_rflags !== 4'b0000) begin
      missCount++; $display("[TB] FAIL add5: acc=%h flags=%b, required 05 0000", acc, alu_rflags);
    end
    vecCount++;
    if (imem_addr !== 8'h01 || alu_en !== 1'b0) begin
      missCount++; $display("[TB] FAIL add5_next: addr=%h en=%b, required 01 0", imem_addr, alu_en);
    end
    // imem_valid held high with junk outside FETCH must be ignored
    applyStimulus(16'h40FF);
    imem_data  = 16'hFFFF;
    imem_valid = 1'b1;
    repeat (3) @(negedge clk);
    imem_valid = 1'b0;
    vecCount++;
    if (acc !== 8'h04 || alu_rflags !== 4'b0100) begin
      missCount++; $display("[TB] FAIL addFF: acc=%h flags=%b, required 04 0100", acc, alu_rflags);
    end
    vecCount++;
    if (imem_addr !== 8'h02) begin
      missCount++; $display("[TB] FAIL addFF_addr: got %h, required 02", imem_addr);
    end
  endtask

  task automatic test_carry_retention();
    applyStimulus(16'h5000);
    repeat (3) @(negedge clk);
    vecCount++;
    if (acc !== 8'h00 || alu_rflags !== 4'b1100) begin
      missCount++; $display("[TB] FAIL and0_carry: acc=%h flags=%b, required 00 1100", acc, alu_rflags);
    end
  endtask

  task automatic test_jumps();
    applyStimulus(16'h9020);
    vecCount++;
    if (imem_req !== 1'b0 || alu_en !== 1'b0) begin
      missCount++; $display("[TB] FAIL jmp_decode: req=%b en=%b, required 0 0", imem_req, alu_en);
    end
    @(negedge clk);
    vecCount++;
    if (imem_addr !== 8'h20 || imem_req !== 1'b1) begin
      missCount++; $display("[TB] FAIL jz_taken: addr=%h req=%b, required 20 1", imem_addr, imem_req);
    end
    applyStimulus(16'h9820);
    @(negedge clk);
    vecCount++;
    if (imem_addr !== 8'h21) begin
      missCount++; $display("[TB] FAIL jnz_not_taken: got %h, required 21", imem_addr);
    end
    applyStimulus(16'hA040);
    @(negedge clk);
    vecCount++;
    if (imem_addr !== 8'h40) begin
      missCount++; $display("[TB] FAIL jc_taken: got %h, required 40", imem_addr);
    end
    applyStimulus(16'h8850);
    @(negedge clk);
    vecCount++;
    if (imem_addr !== 8'h50) begin
      missCount++; $display("[TB] FAIL jmp_always_invert: got %h, required 50", imem_addr);
    end
    applyStimulus(16'hB060);
    @(negedge clk);
    vecCount++;
    if (imem_addr !== 8'h51) begin
      missCount++; $display("[TB] FAIL js_not_taken: got %h, required 51", imem_addr);
    end
    applyStimulus(16'h8051);
    @(negedge clk);
    vecCount++;
    if (imem_addr !== 8'h51) begin
      missCount++; $display("[TB] FAIL jmp_self: got %h, required 51", imem_addr);
    end
  endtask

  task automatic test_nop();
    applyStimulus(16'hC000);
    @(negedge clk);
    vecCount++;
    if (imem_addr !== 8'h52 || halted !== 1'b0 || acc !== 8'h00 || imem_req !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL nop: addr=%h halted=%b acc=%h req=%b, required 52 0 00 1", imem_addr, halted, acc, imem_req);
    end
  endtask

  task automatic test_fetch_stall();
    imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecCount++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h52 || alu_en !== 1'b0) begin
        missCount++;
        $display("[TB] FAIL stall_%0d: req=%b addr=%h en=%b, required 1 52 0", i, imem_req, imem_addr, alu_en);
      end
    end
    applyStimulus(16'h405A);
    repeat (3) @(negedge clk);
    vecCount++;
    if (acc !== 8'h5A || alu_rflags !== 4'b0000 || imem_addr !== 8'h53) begin
      missCount++;
      $display("[TB] FAIL stall_proceed: acc=%h flags=%b addr=%h, required 5A 0000 53", acc, alu_rflags, imem_addr);
    end
  endtask

  task automatic test_regfile();
    applyStimulus(16'h0E03);
    @(negedge clk);
    vecCount++;
    if (alu_mode !== 4'b0011 || alu_op1 !== 8'h00 || alu_op2 !== 8'h5A) begin
      missCount++;
      $display("[TB] FAIL or_r3_drive: mode=%b op1=%h op2=%h, required 0011 00 5A", alu_mode, alu_op1, alu_op2);
    end
    repeat (2) @(negedge clk);
    vecCount++;
    if (acc !== 8'h5A || alu_rflags !== 4'b0000 || imem_addr !== 8'h54) begin
      missCount++;
      $display("[TB] FAIL or_r3_result: acc=%h flags=%b addr=%h, required 5A 0000 54", acc, alu_rflags, imem_addr);
    end
    applyStimulus(16'h0003);
    @(negedge clk);
    vecCount++;
    if (alu_op1 !== 8'h5A) begin
      missCount++; $display("[TB] FAIL r3_readback: got %h, required 5A", alu_op1);
    end
    repeat (2) @(negedge clk);
    vecCount++;
    if (acc !== 8'hB4 || alu_rflags !== 4'b0011) begin
      missCount++; $display("[TB] FAIL add_r3: acc=%h flags=%b, required B4 0011", acc, alu_rflags);
    end
  endtask

  task automatic test_pc_wrap();
    applyStimulus(16'h80FF);
    @(negedge clk);
    vecCount++;
    if (imem_addr !== 8'hFF) begin
      missCount++; $display("[TB] FAIL jmp_ff: got %h, required FF", imem_addr);
    end
    applyStimulus(16'hC000);
    @(negedge clk);
    vecCount++;
    if (imem_addr !== 8'h00) begin
      missCount++; $display("[TB] FAIL pc_wrap: got %h, required 00", imem_addr);
    end
  endtask

  task automatic test_halt();
    applyStimulus(16'hD000);
    @(negedge clk);
    imem_data  = 16'h4005;
    imem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vecCount++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || alu_en !== 1'b0 || imem_addr !== 8'h01 || acc !== 8'hB4) begin
        missCount++;
        $display("[TB] FAIL halt_%0d: halted=%b req=%b en=%b addr=%h acc=%h, required 1 0 0 01 B4", i, halted, imem_req, alu_en, imem_addr, acc);
      end
      @(negedge clk);
    end
    imem_valid = 1'b0;
  endtask

  task automatic test_reset_abort();
    rst_n = 1'b0;
    #1;
    vecCount++;
    if (halted !== 1'b0 || imem_addr !== 8'h00 || acc !== 8'h00) begin
      missCount++;
      $display("[TB] FAIL halt_reset: halted=%b addr=%h acc=%h, required 0 00 00", halted, imem_addr, acc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(16'h4007);
    repeat (3) @(negedge clk);
    vecCount++;
    if (acc !== 8'h07) begin
      missCount++; $display("[TB] FAIL pre_abort_acc: got %h, required 07", acc);
    end
    applyStimulus(16'h4010);
    @(negedge clk);
    vecCount++;
    if (alu_en !== 1'b1) begin
      missCount++; $display("[TB] FAIL abort_in_exec: alu_en=%b, required 1", alu_en);
    end
    rst_n = 1'b0;
    #1;
    vecCount++;
    if (acc !== 8'h00 || alu_en !== 1'b0 || alu_mode !== 4'b0000 || imem_req !== 1'b0 || imem_addr !== 8'h00) begin
      missCount++;
      $display("[TB] FAIL abort_async: acc=%h en=%b mode=%b req=%b addr=%h, required 00 0 0000 0 00", acc, alu_en, alu_mode, imem_req, imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vecCount++;
    if (acc !== 8'h00 || alu_rflags !== 4'b0000 || imem_addr !== 8'h00 || imem_req !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL abort_after: acc=%h flags=%b addr=%h req=%b, required 00 0000 00 1", acc, alu_rflags, imem_addr, imem_req);
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    vecCount   = 0;
    missCount  = 0;
    rst_n      = 1'b0;
    imem_valid = 1'b0;
    imem_data  = 16'h0000;
    test_reset();
    test_alu_imm();
    test_carry_retention();
    test_jumps();
    test_nop();
    test_fetch_stall();
    test_regfile();
    test_pc_wrap();
    test_halt();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
